// File: rtl/uart_pkg.sv
// Shared UART receive types: parity mode encoding, parity-checker states and the
// expected-parity helper used by the checker.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACCUM    = 2'b01,
        WAIT_PAR = 2'b10,
        REPORT   = 2'b11
    } par_state_e;

    // Parity bit the transmitter should have sent, given the XOR of all data bits.
    function automatic logic expected_parity(par_typ_e typ, logic acc);
        logic exp_bit;
        unique case (typ)
            PAR_EVEN:  exp_bit = acc;
            PAR_ODD:   exp_bit = ~acc;
            PAR_MARK:  exp_bit = 1'b1;
            PAR_SPACE: exp_bit = 1'b0;
            default:   exp_bit = 1'b0;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/uart_rx_parity_accum_if.sv
// Strobe/result bundle between the RX sampler (master) and the parity checker (slave).
interface uart_rx_parity_accum_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 frame_start;
    logic                 bit_valid;
    logic                 sampled_bit;
    logic                 par_bit_valid;
    logic                 PAR_EN;
    logic [1:0]           PAR_TYP;
    logic                 par_done;
    logic                 par_err;
    logic                 frm_err;
    logic [CNT_WIDTH-1:0] err_cnt;

    modport master (
        output frame_start, bit_valid, sampled_bit, par_bit_valid, PAR_EN, PAR_TYP,
        input  par_done, par_err, frm_err, err_cnt
    );

    modport slave (
        input  frame_start, bit_valid, sampled_bit, par_bit_valid, PAR_EN, PAR_TYP,
        output par_done, par_err, frm_err, err_cnt
    );
endinterface

// File: rtl/uart_rx_parity_accum.sv
// Sequential UART RX parity checker: XOR-accumulates data bits as they are sampled,
// compares against the received parity bit and reports a sticky parity/sequence error.
// Optional saturating error counter enabled by defining UART_PAR_ERR_CNT_EN.
module uart_rx_parity_accum
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic                    CLK,
    input logic                    RST,
    uart_rx_parity_accum_if.slave  bus
);

    localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);
    localparam logic [BitCntW-1:0] MaxCnt  = BitCntW'(DATA_WIDTH);

    par_state_e         state_q, state_d;
    logic               acc_q, acc_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic               par_en_q, par_en_d;
    par_typ_e           par_typ_q, par_typ_d;
    logic               par_err_q, par_err_d;
    logic               frm_err_q, frm_err_d;
    logic               par_done;

    // State and datapath registers, async active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    // Next state; frame_start restarts from any state and wins over same-cycle strobes.
    always_comb begin
        state_d = state_q;
        if (bus.frame_start) begin
            state_d = ACCUM;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                ACCUM: begin
                    if (bus.par_bit_valid) begin
                        state_d = IDLE;
                    end else if (bus.bit_valid && (bit_cnt_q == LastBit)) begin
                        state_d = par_en_q ? WAIT_PAR : IDLE;
                    end
                end
                WAIT_PAR: begin
                    if (bus.bit_valid) begin
                        state_d = IDLE;
                    end else if (bus.par_bit_valid) begin
                        state_d = REPORT;
                    end
                end
                REPORT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Accumulator, bit counter, latched frame config and sticky error flags.
    always_comb begin
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        if (bus.frame_start) begin
            acc_d     = 1'b0;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
            par_en_d  = bus.PAR_EN;
            par_typ_d = par_typ_e'(bus.PAR_TYP);
        end else begin
            unique case (state_q)
                ACCUM: begin
                    // A parity strobe here (alone or with a data strobe) is out of order.
                    if (bus.par_bit_valid) begin
                        frm_err_d = 1'b1;
                    end else if (bus.bit_valid) begin
                        acc_d = acc_q ^ bus.sampled_bit;
                        if (bit_cnt_q != MaxCnt) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_PAR: begin
                    if (bus.bit_valid) begin
                        frm_err_d = 1'b1;
                    end else if (bus.par_bit_valid) begin
                        par_err_d = bus.sampled_bit != expected_parity(par_typ_q, acc_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: par_done is a Moore decode of the registered state, so it is glitch-free.
    always_comb begin
        par_done = (state_q == REPORT);
    end

    assign bus.par_done = par_done;
    assign bus.par_err  = par_err_q;
    assign bus.frm_err  = frm_err_q;

`ifdef UART_PAR_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of frames that ended with a parity error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (par_done && par_err_q && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_uart_rx_parity_accum.sv
// Self-checking bench for uart_rx_parity_accum: table of directed frames, randomized frames
// against a popcount-based parity model, and hand-written sequence/reset/saturation cases.
module tb_uart_rx_parity_accum;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
`ifdef UART_PAR_ERR_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic [1:0] typ;
        logic       pbit;
        logic       exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   cnt_model;
    vec_t tbl[10];

    uart_rx_parity_accum_if #(.CNT_WIDTH(CW)) bus ();

    uart_rx_parity_accum #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cnt();
        return CntEn ? cnt_model : 0;
    endfunction

    function automatic void bump_cnt();
        if (cnt_model < (1 << CW) - 1) cnt_model++;
    endfunction

    // Parity error from the parity rules, using a popcount of the data byte.
    function automatic logic model_err(input logic [7:0] d, input logic [1:0] typ,
                                       input logic pb);
        int ones;
        int want;
        ones = $countones(d);
        case (typ)
            2'd0:    want = ones % 2;
            2'd1:    want = 1 - (ones % 2);
            2'd2:    want = 1;
            default: want = 0;
        endcase
        return int'(pb) != want;
    endfunction

    task automatic start_frame(input logic pen, input logic [1:0] typ);
        bus.frame_start = 1'b1;
        bus.PAR_EN      = pen;
        bus.PAR_TYP     = typ;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            bus.sampled_bit = data[i];
            bus.bit_valid   = 1'b1;
            tick();
            bus.bit_valid   = 1'b0;
            bus.sampled_bit = 1'($urandom);
            check("done_mid_frame", int'(bus.par_done), 0);
        end
    endtask

    task automatic send_par(input logic pbit);
        bus.sampled_bit   = pbit;
        bus.par_bit_valid = 1'b1;
        tick();
        bus.par_bit_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] data, input logic pen, input logic [1:0] typ,
                             input logic pbit, input logic exp_err);
        start_frame(pen, typ);
        check("start_par_err", int'(bus.par_err), 0);
        check("start_frm_err", int'(bus.frm_err), 0);
        check("start_done", int'(bus.par_done), 0);
        // Mid-frame config changes must be ignored.
        bus.PAR_EN  = ~pen;
        bus.PAR_TYP = typ ^ 2'($urandom_range(1, 3));
        send_bits(data, 8);
        if (pen) begin
            send_par(pbit);
            check("done_pulse", int'(bus.par_done), 1);
            check("par_err", int'(bus.par_err), int'(exp_err));
            check("frm_err_ok", int'(bus.frm_err), 0);
            tick();
            check("done_one_cycle", int'(bus.par_done), 0);
            check("par_err_held", int'(bus.par_err), int'(exp_err));
            if (exp_err) bump_cnt();
            check("err_cnt", int'(bus.err_cnt), exp_cnt());
        end else begin
            repeat (2) begin
                tick();
                check("noparity_done", int'(bus.par_done), 0);
            end
            check("noparity_err", int'(bus.par_err), 0);
            check("noparity_frm", int'(bus.frm_err), 0);
            // Parity strobe in IDLE is ignored.
            send_par(pbit);
            check("idle_strobe_done", int'(bus.par_done), 0);
            tick();
            check("idle_strobe_err", int'(bus.par_err), 0);
            check("idle_strobe_frm", int'(bus.frm_err), 0);
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_done"}, int'(bus.par_done), 0);
        check({tag, "_par_err"}, int'(bus.par_err), 0);
        check({tag, "_frm_err"}, int'(bus.frm_err), 0);
        check({tag, "_err_cnt"}, int'(bus.err_cnt), 0);
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cnt_model = 0;
        bus.frame_start   = 1'b0;
        bus.bit_valid     = 1'b0;
        bus.sampled_bit   = 1'b0;
        bus.par_bit_valid = 1'b0;
        bus.PAR_EN        = 1'b0;
        bus.PAR_TYP       = 2'b00;

        tbl[0] = '{8'hA5, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 2'b01, 1'b0, 1'b1};
        tbl[2] = '{8'h3C, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b1, 2'b11, 1'b1, 1'b1};
        tbl[4] = '{8'hA5, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 1'b1, 2'b01, 1'b1, 1'b0};
        tbl[7] = '{8'h01, 1'b1, 2'b00, 1'b0, 1'b1};
        tbl[8] = '{8'h80, 1'b1, 2'b10, 1'b1, 1'b0};
        tbl[9] = '{8'h7F, 1'b1, 2'b11, 1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", int'(bus.par_done), 0);
        check("rst_par_err", int'(bus.par_err), 0);
        check("rst_frm_err", int'(bus.frm_err), 0);
        check("rst_err_cnt", int'(bus.err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i].data, tbl[i].pen, tbl[i].typ, tbl[i].pbit, tbl[i].exp_err);
        end

        // Abort after 3 data bits, then a clean 0x01 even frame with parity 1.
        start_frame(1'b1, 2'b00);
        send_bits(8'h07, 3);
        run_frame(8'h01, 1'b1, 2'b00, 1'b1, 1'b0);

        // frame_start wins over a same-cycle data strobe in ACCUM.
        start_frame(1'b1, 2'b00);
        send_bits(8'h01, 2);
        bus.bit_valid   = 1'b1;
        bus.sampled_bit = 1'b1;
        start_frame(1'b1, 2'b00);
        bus.bit_valid   = 1'b0;
        send_bits(8'h00, 8);
        send_par(1'b0);
        check("prio_done", int'(bus.par_done), 1);
        check("prio_par_err", int'(bus.par_err), 0);
        check("prio_frm_err", int'(bus.frm_err), 0);
        tick();

        // Parity strobe after 5 data bits, then data strobes while idle.
        start_frame(1'b1, 2'b00);
        send_bits(8'hA5, 5);
        send_par(1'b1);
        check("early_par_frm", int'(bus.frm_err), 1);
        check("early_par_done", int'(bus.par_done), 0);
        check("early_par_err", int'(bus.par_err), 0);
        send_bits(8'hFF, 3);
        check("early_par_held", int'(bus.frm_err), 1);
        start_frame(1'b1, 2'b00);
        check("frm_cleared", int'(bus.frm_err), 0);

        // Extra data bit while waiting for parity.
        send_bits(8'h11, 8);
        send_bits(8'h01, 1);
        check("wait_bit_frm", int'(bus.frm_err), 1);
        tick();
        check("wait_bit_done", int'(bus.par_done), 0);

        // Simultaneous strobes while waiting for parity.
        start_frame(1'b1, 2'b01);
        send_bits(8'h22, 8);
        bus.bit_valid = 1'b1;
        send_par(1'b0);
        bus.bit_valid = 1'b0;
        check("both_wait_frm", int'(bus.frm_err), 1);
        check("both_wait_done", int'(bus.par_done), 0);

        // Randomized frames against the popcount model, with occasional aborts.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] d;
            logic       pen;
            logic [1:0] typ;
            logic       pb;
            if ($urandom_range(0, 4) == 0) begin
                start_frame(1'($urandom), 2'($urandom));
                send_bits(8'($urandom), $urandom_range(1, 7));
            end
            d   = 8'($urandom);
            pen = ($urandom_range(0, 3) != 0);
            typ = 2'($urandom);
            pb  = 1'($urandom);
            run_frame(d, pen, typ, pb, model_err(d, typ, pb));
        end

        // Async reset with a held parity error and non-zero counter.
        run_frame(8'hA5, 1'b1, 2'b01, 1'b0, 1'b1);
        async_reset("rst_held");

        // Async reset mid-frame; a later parity strobe must find the FSM idle.
        start_frame(1'b1, 2'b00);
        send_bits(8'hFF, 3);
        async_reset("rst_mid");
        send_par(1'b0);
        check("post_rst_frm", int'(bus.frm_err), 0);
        check("post_rst_done", int'(bus.par_done), 0);
        tick();
        check("post_rst_done2", int'(bus.par_done), 0);

        // Simultaneous strobes in ACCUM, then async reset clears frm_err.
        start_frame(1'b1, 2'b00);
        send_bits(8'h03, 2);
        bus.bit_valid = 1'b1;
        send_par(1'b1);
        bus.bit_valid = 1'b0;
        check("both_accum_frm", int'(bus.frm_err), 1);
        async_reset("rst_frm");

        // Saturation: 2^CW + 1 parity errors.
        for (int k = 0; k < (1 << CW) + 1; k++) begin
            start_frame(1'b1, 2'b01);
            for (int b = 0; b < 8; b++) begin
                bus.sampled_bit = 1'b0;
                bus.bit_valid   = 1'b1;
                tick();
            end
            bus.bit_valid = 1'b0;
            send_par(1'b0);
            tick();
            bump_cnt();
        end
        check("sat_par_err", int'(bus.par_err), 1);
        check("sat_err_cnt", int'(bus.err_cnt), exp_cnt());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
